// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage with a single registered output slot.
// Decodes the incoming instruction, reads operands from the register file
// and detects load-use and writeback hazards.
// Optional feature macro: DECODE_FORWARD_EN. When defined, a register being
// written back in the same cycle is forwarded into the operand. When it is
// undefined, that case stalls the stage for the cycle instead.
module decode_stage (
    input  logic        clk,
    input  logic        res,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_a3,
    input  logic [31:0] wb_wd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_is_load,
    output logic        out_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_u;
    logic        is_j;
    logic        is_r;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        legal;
    logic [31:0] imm;
    logic        wb_hit1;
    logic        wb_hit2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        load_use;
    logic        fwd_stall;
    logic        stall;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    assign is_i     = (opcode == OP_LOAD) || (opcode == OP_IMM) || (opcode == OP_JALR);
    assign is_s     = (opcode == OP_STORE);
    assign is_b     = (opcode == OP_BRANCH);
    assign is_u     = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j     = (opcode == OP_JAL);
    assign is_r     = (opcode == OP_REG);
    assign legal    = is_i || is_s || is_b || is_u || is_j || is_r || (opcode == OP_SYSTEM);
    assign uses_rs1 = !(is_u || is_j);
    assign uses_rs2 = is_r || is_s || is_b;
    assign rd       = (is_s || is_b) ? 5'd0 : in_instr[11:7];

    // Immediate generation by instruction format; R-type and others give zero
    always_comb begin
        imm = '0;
        if (is_i)
            imm = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (is_s)
            imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (is_b)
            imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        else if (is_u)
            imm = {in_instr[31:12], 12'h000};
        else if (is_j)
            imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    end

    // Raw field match against the writeback port; x0 never matches
    assign wb_hit1 = wb_we && (wb_a3 != 5'd0) && (wb_a3 == rs1);
    assign wb_hit2 = wb_we && (wb_a3 != 5'd0) && (wb_a3 == rs2);

    // The bypass mux is shared by both builds: without forwarding a hit on a
    // used source stalls, so a bypassed value is never captured.
    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
        if (rs1 == 5'd0)
            rs1_val = '0;
        else if (wb_hit1)
            rs1_val = wb_wd;
        if (rs2 == 5'd0)
            rs2_val = '0;
        else if (wb_hit2)
            rs2_val = wb_wd;
    end

`ifdef DECODE_FORWARD_EN
    assign fwd_stall = 1'b0;
`else
    assign fwd_stall = (uses_rs1 && wb_hit1) || (uses_rs2 && wb_hit2);
`endif

    assign load_use = out_valid && out_is_load && (out_rd != 5'd0) &&
                      ((uses_rs1 && (out_rd == rs1)) || (uses_rs2 && (out_rd == rs2)));
    assign stall    = in_valid && (load_use || fwd_stall);
    assign in_ready = res && (flush || ((!out_valid || out_ready) && !stall));
    assign accept   = in_valid && in_ready;

    // Output slot: flush wins, accept loads, transfer alone empties
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_is_load  <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (accept && !flush) begin
                out_pc       <= in_pc;
                out_rs1_val  <= rs1_val;
                out_rs2_val  <= rs2_val;
                out_imm      <= imm;
                out_rd       <= rd;
                out_opcode   <= opcode;
                out_funct3   <= in_instr[14:12];
                out_funct7b5 <= in_instr[30];
                out_is_load  <= (opcode == OP_LOAD);
                out_illegal  <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural model of the stage. Honours DECODE_FORWARD_EN.
module tb_decode_stage;

    logic        clk;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_is_load;
    logic        out_illegal;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ld;
        logic        ill;
    } dec_t;

    logic [6:0] ops [13] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                             7'h6F, 7'h33, 7'h73, 7'h0B, 7'h7F, 7'h00};

    decode_stage dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_a3(wb_a3),
        .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_is_load(out_is_load), .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_instr = 32'h0000_0013; in_pc = '0;
        rf_rd1 = '0; rf_rd2 = '0; wb_we = 1'b0; wb_a3 = '0; wb_wd = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    // Reference decode written from the ISA format rules with plain arithmetic
    function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2,
                                        input logic we, input logic [4:0] a3,
                                        input logic [31:0] wd);
        dec_t d;
        int signed s;
        logic [6:0] op;
        s  = $signed(w);
        op = w[6:0];
        d.pc = pc;
        d.op = op;
        d.f3 = w[14:12];
        d.f7 = w[30];
        d.ld = (op == 7'h03);
        d.ill = !(op inside {7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73});
        if (op inside {7'h03, 7'h13, 7'h67})      d.imm = 32'(s >>> 20);
        else if (op == 7'h23)                     d.imm = 32'((s >>> 25) * 32 + int'(w[11:7]));
        else if (op == 7'h63)                     d.imm = 32'((s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
        else if (op inside {7'h37, 7'h17})        d.imm = w & 32'hFFFF_F000;
        else if (op == 7'h6F)                     d.imm = 32'((s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
        else                                      d.imm = '0;
        d.rd   = (op == 7'h23 || op == 7'h63) ? 5'd0 : w[11:7];
        d.rs1v = (w[19:15] == 0) ? 32'd0 : (we && a3 == w[19:15]) ? wd : r1;
        d.rs2v = (w[24:20] == 0) ? 32'd0 : (we && a3 == w[24:20]) ? wd : r2;
        return d;
    endfunction

    task automatic test_reset();
        idle_inputs();
        res = 1'b0;
        in_valid = 1'b1;
        in_instr = $urandom;
        repeat (2) tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        vectors++; if ({out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_opcode, out_funct3, out_funct7b5, out_is_load, out_illegal} !== '0) begin
            errors++; $display("FAIL reset_data: got pc=%h imm=%h rd=%0d op=%h want all zero", out_pc, out_imm, out_rd, out_opcode); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        res = 1'b1;
        in_valid = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_addi();
        idle_inputs();
        in_valid = 1'b1; in_instr = 32'h02A0_0293; in_pc = 32'h100; rf_rd1 = 32'hDEAD_BEEF;
        #1;
        vectors++; if (in_ready !== 1'b1 || rf_a1 !== 5'd0) begin errors++; $display("FAIL addi_accept: got ready=%0b a1=%0d want 1/0", in_ready, rf_a1); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_imm !== 32'd42 || out_opcode !== 7'h13 ||
                       out_rs1_val !== 32'd0 || out_pc !== 32'h100 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL addi_out: got v=%0b rd=%0d imm=%0d op=%h rs1=%h pc=%h ill=%0b want 1/5/42/13/0/100/0",
                               out_valid, out_rd, out_imm, out_opcode, out_rs1_val, out_pc, out_illegal); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h200;
        tick();
        out_ready = 1'b0; in_instr = 32'h0020_0113; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_imm !== 32'd1) begin
                errors++; $display("FAIL hold_%0d: got ready=%0b v=%0b pc=%h imm=%0d want 0/1/200/1", i, in_ready, out_valid, out_pc, out_imm); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_imm !== 32'd2 || out_rd !== 5'd2) begin
            errors++; $display("FAIL next_instr: got v=%0b pc=%h imm=%0d rd=%0d want 1/204/2/2", out_valid, out_pc, out_imm, out_rd); end
        tick();
    endtask

    task automatic test_load_use();
        int bubbles = 0;
        idle_inputs();
        in_valid = 1'b1; in_instr = 32'h0002_A303; in_pc = 32'h300; rf_rd1 = 32'h1000;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_is_load !== 1'b1 || out_rd !== 5'd6) begin
            errors++; $display("FAIL lw_out: got v=%0b ld=%0b rd=%0d want 1/1/6", out_valid, out_is_load, out_rd); end
        in_instr = 32'h0053_03B3; in_pc = 32'h304;
        #1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_use_stall: got ready=%0b want 0", in_ready); end
        for (int i = 0; i < 4 && !(out_valid === 1'b1 && out_pc === 32'h304); i++) begin
            tick();
            if (out_valid === 1'b0) bubbles++;
        end
        in_valid = 1'b0;
        vectors++; if (bubbles != 1 || out_pc !== 32'h304 || out_rd !== 5'd7) begin
            errors++; $display("FAIL load_use_bubble: got bubbles=%0d pc=%h rd=%0d want 1/304/7", bubbles, out_pc, out_rd); end
        tick();
    endtask

    task automatic test_forward();
        idle_inputs();
        tick();
        in_valid = 1'b1; in_instr = 32'h0005_05B3; in_pc = 32'h400;
        wb_we = 1'b1; wb_a3 = 5'd10; wb_wd = 32'd100; rf_rd1 = 32'd7;
        #1;
`ifdef DECODE_FORWARD_EN
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0; wb_we = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_rs1_val !== 32'd100 || out_rs2_val !== 32'd0 || out_rd !== 5'd11) begin
            errors++; $display("FAIL fwd_value: got v=%0b rs1=%0d rs2=%0d rd=%0d want 1/100/0/11", out_valid, out_rs1_val, out_rs2_val, out_rd); end
`else
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wb_stall: got %0b want 0", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wb_stall_bubble: got %0b want 0", out_valid); end
        wb_we = 1'b0; rf_rd1 = 32'd100;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_resume: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_rs1_val !== 32'd100 || out_rd !== 5'd11) begin
            errors++; $display("FAIL wb_value: got v=%0b rs1=%0d rd=%0d want 1/100/11", out_valid, out_rs1_val, out_rd); end
`endif
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h500;
        tick();
        out_ready = 1'b0; flush = 1'b1; in_instr = 32'h0020_0113; in_pc = 32'h504;
        #1;
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got ready=%0b v=%0b want 1/1", in_ready, out_valid); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_%0d: got v=%0b pc=%h want 0", i, out_valid, out_pc); end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        idle_inputs();
        in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h600;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        res = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_imm !== 32'd0) begin
            errors++; $display("FAIL async_reset: got v=%0b pc=%h imm=%h want 0/0/0", out_valid, out_pc, out_imm); end
        tick();
        res = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h604;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h604) begin
            errors++; $display("FAIL post_reset_accept: got v=%0b pc=%h want 1/604", out_valid, out_pc); end
        tick();
    endtask

    task automatic test_random();
        bit   mv;
        dec_t md;
        dec_t got;
        logic [31:0] w;
        logic [6:0]  op;
        bit u1, u2, lu, fs, er;
        idle_inputs();
        res = 1'b0;
        tick();
        res = 1'b1;
        mv = 1'b0;
        md = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            got = {out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_opcode, out_funct3, out_funct7b5, out_is_load, out_illegal};
            vectors++; if (out_valid !== mv) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, out_valid, mv); end
            vectors++; if (got !== md) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, got, md); end

            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 12)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            in_instr  = w;
            in_pc     = $urandom;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            wb_we     = ($urandom_range(0, 3) == 0);
            wb_a3     = 5'($urandom_range(0, 3));
            wb_wd     = $urandom;
            rf_rd1    = $urandom;
            rf_rd2    = $urandom;
            #1;

            op = w[6:0];
            u1 = !(op inside {7'h37, 7'h17, 7'h6F});
            u2 = (op inside {7'h33, 7'h23, 7'h63});
            lu = mv && md.ld && md.rd != 0 && ((u1 && md.rd == w[19:15]) || (u2 && md.rd == w[24:20]));
`ifdef DECODE_FORWARD_EN
            fs = 1'b0;
`else
            fs = wb_we && wb_a3 != 0 && ((u1 && wb_a3 == w[19:15]) || (u2 && wb_a3 == w[24:20]));
`endif
            er = flush || ((!mv || out_ready) && !(in_valid && (lu || fs)));
            vectors++; if (in_ready !== er) begin errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, in_ready, er); end
            vectors++; if (rf_a1 !== w[19:15] || rf_a2 !== w[24:20]) begin
                errors++; $display("FAIL rnd_addr@%0d: got %0d/%0d want %0d/%0d", cyc, rf_a1, rf_a2, w[19:15], w[24:20]); end

            if (flush) mv = 1'b0;
            else if (in_valid && er) begin
                mv = 1'b1;
                md = ref_decode(w, in_pc, rf_rd1, rf_rd2, wb_we, wb_a3, wb_wd);
            end else if (out_ready) mv = 1'b0;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        res = 1'b0;
        idle_inputs();
        test_reset();
        test_addi();
        test_backpressure();
        test_load_use();
        test_forward();
        test_flush();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: none; datapath SHALL be fixed at 32 bits (RV32I).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 res  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream (fetch) has an instruction.
REQ-005 in_ready  output  1  stage accepts in_instr/in_pc this cycle.
REQ-006 in_instr  input  32  instruction word.
REQ-007 in_pc  input  32  instruction address.
REQ-008 rf_a1, rf_a2  output  5 each  register-file read addresses, = in_instr[19:15], in_instr[24:20], combinational.
REQ-009 rf_rd1, rf_rd2  input  32 each  register-file combinational read data.
REQ-010 wb_we, wb_a3, wb_wd  input  1/5/32  writeback port currently driving the register file.
REQ-011 flush  input  1  discard held and incoming instruction.
REQ-012 out_valid  output  1; out_ready  input  1  downstream (execute) handshake.
REQ-013 out_pc, out_rs1_val, out_rs2_val, out_imm  output  32 each; out_rd  output  5; out_opcode  output  7; out_funct3  output  3; out_funct7b5  output  1; out_is_load, out_illegal  output  1 each.

Function
REQ-014 One output register stage; accepted instruction SHALL appear on out_* the cycle after acceptance (latency 1).
REQ-015 Accept = in_valid && in_ready; in_ready = (!out_valid || out_ready) && !stall, where stall = load_use || fwd_stall.
REQ-016 Output transfer = out_valid && out_ready; out_* SHALL hold stable while out_valid && !out_ready.
REQ-017 Transfer without accept SHALL clear out_valid; accept SHALL set it.
REQ-018 Immediate: I (opcodes 0x03,0x13,0x67) sign-ext [31:20]; S (0x23); B (0x63, bit0=0); U (0x37,0x17, low 12 zero); J (0x6F, bit0=0); R (0x33) and others SHALL yield 0.
REQ-019 Register index 0 SHALL read as 0 regardless of rf_rd*/forwarding.
REQ-020 out_illegal SHALL be 1 for any opcode outside REQ-018 list plus 0x73; instruction still passes.
REQ-021 out_is_load = (opcode==0x03); out_rd = 0 for S and B formats.
REQ-022 load_use = out_valid && out_is_load && out_rd!=0 && out_rd matches a used rs (rs1 for all but U/J; rs2 for R/S/B); when set, one bubble SHALL be inserted (out_valid goes 0 after transfer, instruction accepted next cycle).
REQ-023 flush SHALL have priority: next edge out_valid=0, in_ready=1 that cycle, any accepted instruction dropped.

Reset
REQ-024 res low SHALL immediately force out_valid=0 and all out_* data to 0; in_ready SHALL be 0 while res low.
REQ-025 Reset mid-operation SHALL discard held instruction; first accept possible the cycle after res rises.

Configuration
REQ-026 Macro DECODE_FORWARD_EN defined: if wb_we && wb_a3!=0 && wb_a3==rs, operand SHALL take wb_wd; fwd_stall=0.
REQ-027 DECODE_FORWARD_EN undefined: same match SHALL assert fwd_stall for that cycle; operand read from rf_rd* after writeback completes.

Verification
REQ-028 res=0 for 2 cycles with in_valid=1 -> out_valid=0, all out_* 0, in_ready=0; after release in_ready=1.
REQ-029 in_instr=0x02A00293 (addi x5,x0,42), pc=0x100 -> next cycle out_valid=1, out_rd=5, out_imm=42, out_opcode=0x13, out_rs1_val=0, out_pc=0x100.
REQ-030 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_* unchanged; out_ready=1 -> transfer then next instruction appears.
REQ-031 0x0002A303 (lw x6,0(x5)) then 0x005303B3 (add x7,x6,x5), out_ready=1 -> exactly one out_valid=0 cycle between them.
REQ-032 0x000505B3 (add x11,x10,x0) with wb_we=1, wb_a3=10, wb_wd=100, rf_rd1=7 -> with macro out_rs1_val=100, no stall; without macro in_ready=0 one cycle, then out_rs1_val=rf_rd1.
REQ-033 flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0; neither instruction ever transfers.
